// File: rtl/aurora_tx_lane.sv
// aurora_tx_lane: Aurora 64b/66b transmit lane (scrambler, 66->64 gearbox, idle insertion).
// Define TX_POLARITY_EN to add tx_polarity_i, which inverts whole line words two clocks later.
module aurora_tx_lane #(
    parameter int IDLE_CNT_W = 16
) (
    input  logic                  clk_tx_i,
    input  logic                  rst_n_i,
    input  logic [63:0]           tx_data_i,
    input  logic [1:0]            tx_header_i,
    input  logic                  tx_valid_i,
`ifdef TX_POLARITY_EN
    input  logic                  tx_polarity_i,
`endif
    output logic                  tx_ready_o,
    output logic [63:0]           tx_word_o,
    output logic [IDLE_CNT_W-1:0] tx_idle_cnt_o
);
    logic                  run_q, run_d;
    logic [5:0]            seq_q, seq_d;
    logic [57:0]           scr_q, scr_d, scr_t;
    logic [63:0]           res_q, res_d;
    logic [63:0]           word_q, word_d, word_t;
    logic [IDLE_CNT_W-1:0] idle_q, idle_d;
    logic                  idle_ins;
    logic [63:0]           pay, spay;
    logic [1:0]            hdr;
    logic [65:0]           blk;
    logic [129:0]          cat;
    logic [6:0]            sh;
    logic                  s;
    logic                  pol;
`ifdef TX_POLARITY_EN
    logic                  pol_q;
    always_ff @(posedge clk_tx_i or negedge rst_n_i)
        if (!rst_n_i) pol_q <= 1'b0;
        else          pol_q <= tx_polarity_i;
    assign pol = pol_q;
`else
    assign pol = 1'b0;
`endif
    always_comb begin
        tx_ready_o = run_q && (seq_q != 6'd32);
        idle_ins   = tx_ready_o && !tx_valid_i;
        hdr        = idle_ins ? 2'b10 : tx_header_i;
        pay        = idle_ins ? {8'h78, 56'h0} : tx_data_i;
        scr_t      = scr_q;
        spay       = '0;
        s          = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            s       = pay[i] ^ scr_t[38] ^ scr_t[57];
            spay[i] = s;
            scr_t   = {scr_t[56:0], s};
        end
        blk    = {hdr, spay};
        cat    = {res_q, blk};
        // top 64 bits of {R_k, B} start just below the 2k+2 bits kept as the new residual
        sh     = {seq_q, 1'b0} + 7'd2;
        run_d  = 1'b1;
        seq_d  = !run_q ? 6'd0 : (seq_q == 6'd32 ? 6'd0 : seq_q + 6'd1);
        scr_d  = tx_ready_o ? scr_t : scr_q;
        word_t = '0;
        res_d  = res_q;
        if (tx_ready_o) begin
            word_t = 64'(cat >> sh);
            res_d  = blk[63:0] & ~({64{1'b1}} << sh);
        end else if (run_q) begin
            word_t = res_q;
            res_d  = '0;
        end
        word_d = word_t ^ {64{pol}};
        idle_d = (idle_ins && !(&idle_q)) ? idle_q + IDLE_CNT_W'(1) : idle_q;
    end
    always_ff @(posedge clk_tx_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            run_q  <= 1'b0;
            seq_q  <= '0;
            scr_q  <= 58'h3FF_FFFF_FFFF_FFFF;
            res_q  <= '0;
            word_q <= '0;
            idle_q <= '0;
        end else begin
            run_q  <= run_d;
            seq_q  <= seq_d;
            scr_q  <= scr_d;
            res_q  <= res_d;
            word_q <= word_d;
            idle_q <= idle_d;
        end
    end
    assign tx_word_o     = word_q;
    assign tx_idle_cnt_o = idle_q;
endmodule

// File: tb/tb_aurora_tx_lane.sv
// tb_aurora_tx_lane: scoreboard bench; a bit-serial line model queues expected bits per consumed block.
module tb_aurora_tx_lane;
    logic        clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst_n;
    logic [63:0] data;
    logic [1:0]  hdr;
    logic        valid;
    logic        ready, ready4;
    logic [63:0] word, word4;
    logic [15:0] idle;
    logic [3:0]  idle4;
`ifdef TX_POLARITY_EN
    logic        pol = 1'b0;
`endif
    aurora_tx_lane dut (
        .clk_tx_i(clk), .rst_n_i(rst_n), .tx_data_i(data), .tx_header_i(hdr), .tx_valid_i(valid),
`ifdef TX_POLARITY_EN
        .tx_polarity_i(pol),
`endif
        .tx_ready_o(ready), .tx_word_o(word), .tx_idle_cnt_o(idle));
    aurora_tx_lane #(.IDLE_CNT_W(4)) dut4 (
        .clk_tx_i(clk), .rst_n_i(rst_n), .tx_data_i(data), .tx_header_i(hdr), .tx_valid_i(valid),
`ifdef TX_POLARITY_EN
        .tx_polarity_i(pol),
`endif
        .tx_ready_o(ready4), .tx_word_o(word4), .tx_idle_cnt_o(idle4));
    int          n_chk = 0, n_pass = 0;
    int          c, exp_idle, n_acc;
    logic [31:0] cnt;
    logic [57:0] sc;
    bit          sb[$];
    bit          a;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask
    task automatic model_reset();
        c = 0;
        sc = '1;
        sb.delete();
        exp_idle = 0;
    endtask
    task automatic tick(output bit acc);
        logic        er, s;
        logic [65:0] b;
        logic [63:0] w;
        er  = (c != 0) && (((c - 1) % 33) != 32);
        chk("ready", {63'b0, ready}, {63'b0, er});
        acc = er && valid;
        b   = acc ? {hdr, data} : {2'b10, 8'h78, 56'h0};
        @(posedge clk);
        #1;
        if (er) begin
            if (!valid && exp_idle < 65535) exp_idle++;
            for (int i = 63; i >= 0; i--) begin
                s    = b[i] ^ sc[38] ^ sc[57];
                sc   = {sc[56:0], s};
                b[i] = s;
            end
            for (int i = 65; i >= 0; i--) sb.push_back(b[i]);
        end
        c++;
        if (sb.size() >= 64) begin
            w = '0;
            for (int i = 63; i >= 0; i--) w[i] = sb.pop_front();
            chk("word", word, w);
        end
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask
    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        data  = '0;
        hdr   = 2'b01;
        model_reset();
        #12;
        chk("rst_word", word, 64'h0);
        chk("rst_ready", {63'b0, ready}, 64'h0);
        chk("rst_idle", {48'b0, idle}, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (66) tick(a);
        chk("idle64", {48'b0, idle}, 64'd64);
        chk("idle_sat4", {60'b0, idle4}, 64'hF);
        do_reset();
        cnt   = 0;
        n_acc = 0;
        valid = 1'b1;
        hdr   = 2'b01;
        data  = {cnt, cnt};
        repeat (330) begin
            tick(a);
            if (a) begin
                n_acc++;
                if (n_acc == 1) chk("first_hdr", {62'b0, word[63:62]}, 64'd1);
                cnt++;
                data = {cnt, cnt};
            end
        end
        chk("acc320", 64'(n_acc), 64'd320);
        chk("idle_stream", {48'b0, idle}, 64'(exp_idle));
        for (int k = 0; k < 300; k++) begin
            valid = 1'($urandom_range(0, 1));
            hdr   = $urandom_range(0, 1) ? 2'b01 : 2'b10;
            data  = {$urandom, $urandom};
            tick(a);
        end
        chk("idle_rand", {48'b0, idle}, 64'(exp_idle));
        do_reset();
        valid = 1'b0;
        repeat (18) tick(a);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_word", word, 64'h0);
        chk("mid_rst_ready", {63'b0, ready}, 64'h0);
        chk("mid_rst_idle", {48'b0, idle}, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        valid = 1'b1;
        hdr   = 2'b01;
        data  = 64'h0123_4567_89AB_CDEF;
        repeat (40) begin
            tick(a);
            if (a) data = {$urandom, $urandom};
        end
        chk("idle_end", {48'b0, idle}, 64'(exp_idle));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
